if_fetch_ctrl: RTL

Instruction-fetch controller sitting directly upstream of the branch target buffer (BTB). It owns the PC register and drives fetch_pc/fetch_en into the BTB. It consumes the BTB prediction (ret_en/taken/ret_pc/ret_index) one cycle later to choose the next PC. It issues requests on the instruction-SRAM request/response bus and buffers the returned instructions with their prediction info in an in-order fetch queue for decode.

---
 rtl/if_fetch_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller sitting in front of the BTB.
// Owns the PC, issues one SRAM request every other cycle at most, uses the
// BTB answer in the following cycle to pick the next PC, and buffers the
// returned instructions with their prediction info in an in-order queue.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1C000000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] fetch_pc,
    output logic        fetch_en,
    input  logic [31:0] btb_ret_pc,
    input  logic        btb_taken,
    input  logic        btb_ret_en,
    input  logic [4:0]  btb_ret_index,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic [38:0] fs_pred,
    input  logic        ds_allowin
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(FQ_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FQ_DEPTH);

    typedef enum logic {ST_REQ, ST_PRED} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_r, pc_d;
    logic [CW-1:0] outstanding, outstanding_d;
    logic [CW-1:0] discard, discard_d;
    logic [CW-1:0] queue_count;
    logic [PW-1:0] iss_ptr, rsp_ptr, pred_ptr;
    logic [PW-1:0] q_rd_ptr, q_wr_ptr;

    logic [31:0]   fl_pc   [FQ_DEPTH];
    logic [38:0]   fl_pred [FQ_DEPTH];
    logic [31:0]   q_pc    [FQ_DEPTH];
    logic [31:0]   q_inst  [FQ_DEPTH];
    logic [38:0]   q_pred  [FQ_DEPTH];

    logic          credit_ok, accept, push, pop, resp_bypass;
    logic [31:0]   pred_next_pc;
    logic [38:0]   pred_info, push_pred;

    // Request issue, BTB strobe and the predicted successor of the issued PC
    always_comb begin
        credit_ok    = ({1'b0, outstanding} + {1'b0, queue_count}) < DEPTH_SUM;
        inst_req     = !reset && (state_q == ST_REQ) && credit_ok;
        accept       = inst_req && inst_addr_ok;
        fetch_en     = accept && !redirect_valid;
        fetch_pc     = pc_r;
        inst_addr    = pc_r;
        pred_next_pc = (btb_ret_en && btb_taken) ? {btb_ret_pc[31:2], 2'b00}
                                                 : pc_r + 32'd4;
        pred_info    = {btb_ret_en, btb_taken, btb_ret_index, pred_next_pc};
        pred_ptr     = iss_ptr - PW'(1);
        // a response can land in the very cycle its prediction is being
        // produced; then the slot is not written yet and the live value is used
        resp_bypass  = (state_q == ST_PRED) && (rsp_ptr == pred_ptr);
        push_pred    = resp_bypass ? pred_info : fl_pred[rsp_ptr];
        push         = inst_data_ok && (discard == '0) && !redirect_valid;
        pop          = fs_valid && ds_allowin;
        fs_valid     = (queue_count != '0);
        fs_pc        = q_pc[q_rd_ptr];
        fs_inst      = q_inst[q_rd_ptr];
        fs_pred      = q_pred[q_rd_ptr];
    end

    // Next state and next PC; a redirect overrides everything
    always_comb begin
        state_d = state_q;
        pc_d    = pc_r;
        case (state_q)
            ST_REQ:  if (accept) state_d = ST_PRED;
            ST_PRED: begin
                state_d = ST_REQ;
                pc_d    = pred_next_pc;
            end
            default: state_d = ST_REQ;
        endcase
        if (redirect_valid) begin
            state_d = ST_REQ;
            pc_d    = redirect_pc;
        end
    end

    // Outstanding-request and discard counters; on a redirect every request
    // still in flight afterwards belongs to the old path
    always_comb begin
        outstanding_d = outstanding;
        if (accept && !inst_data_ok)
            outstanding_d = outstanding + CW'(1);
        else if (!accept && inst_data_ok)
            outstanding_d = outstanding - CW'(1);
        discard_d = discard;
        if (redirect_valid)
            discard_d = outstanding_d;
        else if (inst_data_ok && (discard != '0))
            discard_d = discard - CW'(1);
    end

    // FSM state and PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_r    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_r    <= pc_d;
        end
    end

    // Request bookkeeping counters and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            discard     <= '0;
            iss_ptr     <= '0;
            rsp_ptr     <= '0;
        end else begin
            outstanding <= outstanding_d;
            discard     <= discard_d;
            if (accept)       iss_ptr <= iss_ptr + PW'(1);
            if (inst_data_ok) rsp_ptr <= rsp_ptr + PW'(1);
        end
    end

    // In-flight ring: PC at issue, prediction info one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fl_pc[i]   <= '0;
                fl_pred[i] <= '0;
            end
        end else begin
            if (accept)
                fl_pc[iss_ptr] <= pc_r;
            if ((state_q == ST_PRED) && !redirect_valid)
                fl_pred[pred_ptr] <= pred_info;
        end
    end

    // Fetch queue towards decode; flushed on redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_rd_ptr    <= '0;
            q_wr_ptr    <= '0;
            queue_count <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
                q_pred[i] <= '0;
            end
        end else if (redirect_valid) begin
            q_rd_ptr    <= '0;
            q_wr_ptr    <= '0;
            queue_count <= '0;
        end else begin
            if (push) begin
                q_pc[q_wr_ptr]   <= fl_pc[rsp_ptr];
                q_inst[q_wr_ptr] <= inst_rdata;
                q_pred[q_wr_ptr] <= push_pred;
                q_wr_ptr         <= q_wr_ptr + PW'(1);
            end
            if (pop)
                q_rd_ptr <= q_rd_ptr + PW'(1);
            if (push && !pop)
                queue_count <= queue_count + CW'(1);
            else if (pop && !push)
                queue_count <= queue_count - CW'(1);
        end
    end

    // Protocol sanity: no overflow of the queue, no response without a request
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && (queue_count == DEPTH_CNT)));
            assert (!(inst_data_ok && (outstanding == '0)));
        end
    end

endmodule
